// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a single-lane TDM link. Hunts for frame sync on
// in_sof, gathers N_CH slots into a shadow buffer and publishes the whole frame
// on out_data with a one-cycle out_frame_valid pulse.
// Optional build macro: TDM_DEMUX_FRAME_CNT_EN enables the completed-frame
// counter on out_frame_cnt; when undefined, out_frame_cnt is tied to zero.
module tdm_demux #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic [N_CH*W-1:0] out_data,
  output logic              out_frame_valid,
  output logic              out_locked,
  output logic              out_sync_err,
  output logic [15:0]       out_frame_cnt
);

  localparam int unsigned SW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [SW-1:0] SLOT_LAST = SW'(N_CH - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                     state;
  logic [SW-1:0]              slot;
  // Only words 0..N_CH-2 are buffered; the last word comes straight from the beat.
  logic [N_CH-2:0][W-1:0]     shadow;
  logic                       frame_done_c;

  // A frame completes when the last slot of a locked frame is accepted without sof.
  assign frame_done_c = in_valid && (state == ST_LOCK) && !in_sof && (slot == SLOT_LAST);

  // Sync FSM, slot tracking, shadow capture and frame publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_HUNT;
      slot            <= '0;
      shadow          <= '0;
      out_data        <= '0;
      out_frame_valid <= 1'b0;
      out_locked      <= 1'b0;
      out_sync_err    <= 1'b0;
    end else begin
      out_frame_valid <= 1'b0;
      out_sync_err    <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_HUNT: begin
            // Non-sof beats are discarded until a frame start is seen.
            if (in_sof) begin
              shadow[0]  <= in_data;
              slot       <= SLOT_ONE;
              state      <= ST_LOCK;
              out_locked <= 1'b1;
            end
          end
          ST_LOCK: begin
            if (slot == '0) begin
              if (in_sof) begin
                shadow[0] <= in_data;
                slot      <= SLOT_ONE;
              end else begin
                // Missing sof: lose lock and go back to hunting.
                out_sync_err <= 1'b1;
                slot         <= '0;
                state        <= ST_HUNT;
                out_locked   <= 1'b0;
              end
            end else if (in_sof) begin
              // Early sof: abandon the partial frame, restart on this beat.
              out_sync_err <= 1'b1;
              shadow[0]    <= in_data;
              slot         <= SLOT_ONE;
            end else if (slot == SLOT_LAST) begin
              for (int unsigned k = 0; k < N_CH - 1; k++) begin
                out_data[k*W +: W] <= shadow[k];
              end
              out_data[(N_CH-1)*W +: W] <= in_data;
              out_frame_valid           <= 1'b1;
              slot                      <= '0;
            end else begin
              for (int unsigned k = 1; k < N_CH - 1; k++) begin
                if (slot == SW'(k)) begin
                  shadow[k] <= in_data;
                end
              end
              slot <= slot + SLOT_ONE;
            end
          end
          default: begin
            state      <= ST_HUNT;
            slot       <= '0;
            out_locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TDM_DEMUX_FRAME_CNT_EN
  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_frame_cnt <= '0;
    end else if (frame_done_c) begin
      out_frame_cnt <= out_frame_cnt + CNT_W'(1);
    end
  end
`else
  assign out_frame_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed table-driven bench for tdm_demux (N_CH=4, W=8).
module tb_tdm_demux;

  localparam int unsigned N_CH = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned DW   = N_CH * W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [W-1:0]  in_data;
  logic [DW-1:0] out_data;
  logic          out_frame_valid;
  logic          out_locked;
  logic          out_sync_err;
  logic [15:0]   out_frame_cnt;

  int n_vec;
  int n_err;

  typedef struct {
    logic          v;
    logic          s;
    logic [W-1:0]  d;
    logic          fv;
    logic          er;
    logic          lk;
    logic [DW-1:0] od;
  } vec_t;

  vec_t vecs[$];

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_sof          (in_sof),
    .in_data         (in_data),
    .out_data        (out_data),
    .out_frame_valid (out_frame_valid),
    .out_locked      (out_locked),
    .out_sync_err    (out_sync_err),
    .out_frame_cnt   (out_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic v, input logic s, input logic [W-1:0] d,
                     input logic fv, input logic er, input logic lk,
                     input logic [DW-1:0] od);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.fv = fv; t.er = er; t.lk = lk; t.od = od;
    vecs.push_back(t);
  endtask

  // Drive one beat at the falling edge, check registered outputs just after the rising edge.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    in_valid = t.v;
    in_sof   = t.s;
    in_data  = t.d;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_frame_valid !== t.fv || out_sync_err !== t.er ||
        out_locked !== t.lk || out_data !== t.od) begin
      n_err++;
      $display("FAIL %s: got fv=%b err=%b lk=%b data=%h, want fv=%b err=%b lk=%b data=%h",
               tag, out_frame_valid, out_sync_err, out_locked, out_data,
               t.fv, t.er, t.lk, t.od);
    end
  endtask

  task automatic beat(input logic s, input logic [W-1:0] d, input logic fv,
                      input logic lk, input logic [DW-1:0] od, input string tag);
    vec_t t;
    t.v = 1'b1; t.s = s; t.d = d; t.fv = fv; t.er = 1'b0; t.lk = lk; t.od = od;
    apply(t, tag);
  endtask

  task automatic check_cnt(input logic [15:0] exp_cnt, input string tag);
    n_vec++;
    if (out_frame_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL %s: got frame_cnt=%0d, want %0d", tag, out_frame_cnt, exp_cnt);
    end
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if (out_data !== '0 || out_frame_valid !== 1'b0 || out_locked !== 1'b0 ||
        out_sync_err !== 1'b0 || out_frame_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL %s: got data=%h fv=%b lk=%b err=%b cnt=%0d, want all zero",
               tag, out_data, out_frame_valid, out_locked, out_sync_err, out_frame_cnt);
    end
  endtask

  initial begin
    logic [15:0] exp_frames;
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;

    // Lock + first frame
    add(1, 1, 8'h11, 0, 0, 1, 32'h0);
    add(1, 0, 8'h22, 0, 0, 1, 32'h0);
    add(1, 0, 8'h33, 0, 0, 1, 32'h0);
    add(1, 0, 8'h44, 1, 0, 1, 32'h44332211);
    // Missing sof at slot 0
    add(1, 0, 8'h99, 0, 1, 0, 32'h44332211);
    // Hunt drops non-sof beats, then a full frame
    add(1, 0, 8'hAA, 0, 0, 0, 32'h44332211);
    add(1, 0, 8'hBB, 0, 0, 0, 32'h44332211);
    add(1, 1, 8'h01, 0, 0, 1, 32'h44332211);
    add(1, 0, 8'h02, 0, 0, 1, 32'h44332211);
    add(1, 0, 8'h03, 0, 0, 1, 32'h44332211);
    add(1, 0, 8'h04, 1, 0, 1, 32'h04030201);
    // Stalls of 3 cycles between beats; stalled junk (sof=1) must be ignored
    add(1, 1, 8'h10, 0, 0, 1, 32'h04030201);
    for (int i = 0; i < 3; i++) add(0, 1, 8'hFF, 0, 0, 1, 32'h04030201);
    add(1, 0, 8'h20, 0, 0, 1, 32'h04030201);
    for (int i = 0; i < 3; i++) add(0, 1, 8'hFF, 0, 0, 1, 32'h04030201);
    add(1, 0, 8'h30, 0, 0, 1, 32'h04030201);
    for (int i = 0; i < 3; i++) add(0, 0, 8'hEE, 0, 0, 1, 32'h04030201);
    add(1, 0, 8'h40, 1, 0, 1, 32'h40302010);
    // Early sof at slot 2
    add(1, 1, 8'h11, 0, 0, 1, 32'h40302010);
    add(1, 0, 8'h22, 0, 0, 1, 32'h40302010);
    add(1, 1, 8'h55, 0, 1, 1, 32'h40302010);
    add(1, 0, 8'h66, 0, 0, 1, 32'h40302010);
    add(1, 0, 8'h77, 0, 0, 1, 32'h40302010);
    add(1, 0, 8'h88, 1, 0, 1, 32'h88776655);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

`ifdef TDM_DEMUX_FRAME_CNT_EN
    exp_frames = 16'd4;
`else
    exp_frames = 16'd0;
`endif
    check_cnt(exp_frames, "cnt_after_table");

    // Reset mid-frame: outputs clear asynchronously, partial frame discarded
    beat(1, 8'hA1, 0, 1, 32'h88776655, "pre_rst_0");
    beat(0, 8'hA2, 0, 1, 32'h88776655, "pre_rst_1");
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three back-to-back frames after reset; first must not contain A1/A2
    beat(1, 8'hC1, 0, 1, 32'h0,        "rf0_s0");
    beat(0, 8'hC2, 0, 1, 32'h0,        "rf0_s1");
    beat(0, 8'hC3, 0, 1, 32'h0,        "rf0_s2");
    beat(0, 8'hC4, 1, 1, 32'hC4C3C2C1, "rf0_s3");
    beat(1, 8'hD1, 0, 1, 32'hC4C3C2C1, "rf1_s0");
    beat(0, 8'hD2, 0, 1, 32'hC4C3C2C1, "rf1_s1");
    beat(0, 8'hD3, 0, 1, 32'hC4C3C2C1, "rf1_s2");
    beat(0, 8'hD4, 1, 1, 32'hD4D3D2D1, "rf1_s3");
    beat(1, 8'hE1, 0, 1, 32'hD4D3D2D1, "rf2_s0");
    beat(0, 8'hE2, 0, 1, 32'hD4D3D2D1, "rf2_s1");
    beat(0, 8'hE3, 0, 1, 32'hD4D3D2D1, "rf2_s2");
    beat(0, 8'hE4, 1, 1, 32'hE4E3E2E1, "rf2_s3");

`ifdef TDM_DEMUX_FRAME_CNT_EN
    exp_frames = 16'd3;
`else
    exp_frames = 16'd0;
`endif
    check_cnt(exp_frames, "cnt_after_reset");

    // Idle cycle: pulse drops, data holds
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_frame_valid !== 1'b0 || out_data !== 32'hE4E3E2E1 || out_locked !== 1'b1) begin
      n_err++;
      $display("FAIL idle_hold: got fv=%b data=%h lk=%b, want fv=0 data=e4e3e2e1 lk=1",
               out_frame_valid, out_data, out_locked);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
